// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage downstream of execute.
// Registers the execute result and runs load/store accesses to data
// memory over a req/ack handshake. While an access is outstanding,
// ex_ready is held low so that execute stalls. The writeback bundle
// sent to the register file is registered.
//
// Optional feature: define DMEM_TIMEOUT_EN to abort an access that
// has gone TIMEOUT_CYCLES cycles without an ack.
//
// Handshake semantics:
//   ex side:   an instruction transfers on a clock edge where
//              ex_valid && ex_ready. ex_ready depends only on the state
//              and never on ex_valid.
//   dmem side: dmem_req rises in the cycle after an aligned load/store
//              is accepted. dmem_req, dmem_we, dmem_addr and dmem_wdata
//              stay stable until the cycle in which dmem_ack is sampled
//              high, and that cycle is included. In that ack cycle the
//              read data is taken from dmem_rdata. dmem_ack is ignored
//              whenever no request is outstanding.
module mem_access_stage #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    // execute-stage side
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [1:0]        mem_op,
    input  logic [32:0]       ex_result,
    input  logic              ex_w_enable,
    input  logic              ex_w_select,
    input  logic [2:0]        dest_reg,
    input  logic [31:0]       base_value,
    input  logic [15:0]       offset,
    input  logic [31:0]       store_data,
    // data-memory side
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    // writeback side
    output logic              wb_valid,
    output logic              w_enable,
    output logic              w_select,
    output logic [2:0]        w_reg,
    output logic [31:0]       w_data,
    output logic              mem_fault,
    // debug: current FSM state (0 = IDLE, 1 = ACCESS)
    output logic              state_dbg
);

    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // The carry bit in ex_result is deliberately dropped.
    logic carry_unused;
    assign carry_unused = ex_result[32];

    // ------------------------------------------------------------------
    // Decode of the instruction on offer
    // ------------------------------------------------------------------
    logic              accept;
    logic              is_mem_op;
    logic [ADDR_W-1:0] eff_addr;
    logic              misaligned;
    logic              start_access;
    logic              access_done;
    logic              timeout_hit;

    assign accept       = ex_valid && ex_ready;
    assign is_mem_op    = (mem_op == OP_LOAD) || (mem_op == OP_STORE);
    // The offset is sign-extended and the sum is truncated to ADDR_W.
    assign eff_addr     = ADDR_W'(base_value) + ADDR_W'($signed(offset));
    assign misaligned   = (eff_addr[1:0] != 2'b00);
    assign start_access = accept && is_mem_op && !misaligned;
    assign access_done  = (state_q == ACCESS) && dmem_ack;

    // ------------------------------------------------------------------
    // Access timeout (optional)
    // ------------------------------------------------------------------
`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_cnt_q;

    // The abort fires at the end of the TIMEOUT_CYCLES-th ACCESS cycle
    // that has no ack. An ack arriving in that same cycle takes
    // priority over the abort.
    assign timeout_hit = (state_q == ACCESS) && !dmem_ack &&
                         (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counts the ACCESS cycles without an ack. It is cleared whenever
    // an access starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else if (start_access) begin
            wait_cnt_q <= '0;
        end else if ((state_q == ACCESS) && !dmem_ack && !timeout_hit) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: move to ACCESS on an aligned load/store, and
    // return to IDLE on an ack or a timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_access) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (access_done || timeout_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs: stall execute and drive the request while
    // in ACCESS.
    always_comb begin
        ex_ready  = 1'b0;
        dmem_req  = 1'b0;
        state_dbg = 1'b0;
        case (state_q)
            IDLE: begin
                ex_ready  = 1'b1;
            end
            ACCESS: begin
                dmem_req  = 1'b1;
                state_dbg = 1'b1;
            end
            default: begin
                ex_ready  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request payload and latched destination
    // ------------------------------------------------------------------
    logic       lat_w_select;
    logic [2:0] lat_dest_reg;

    // Capture the memory request payload when an access starts. It is
    // then held stable for the whole ACCESS period.
    always_ff @(posedge clk) begin
        if (reset) begin
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            lat_w_select <= 1'b0;
            lat_dest_reg <= '0;
        end else if (start_access) begin
            dmem_we      <= (mem_op == OP_STORE);
            dmem_addr    <= eff_addr;
            dmem_wdata   <= store_data;
            lat_w_select <= ex_w_select;
            lat_dest_reg <= dest_reg;
        end
    end

    // ------------------------------------------------------------------
    // Writeback bundle and fault pulse
    // ------------------------------------------------------------------
    // wb_valid, w_enable and mem_fault are one-cycle pulses. w_data,
    // w_reg and w_select keep their values until the next writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid  <= 1'b0;
            w_enable  <= 1'b0;
            w_select  <= 1'b0;
            w_reg     <= '0;
            w_data    <= '0;
            mem_fault <= 1'b0;
        end else begin
            wb_valid  <= 1'b0;
            w_enable  <= 1'b0;
            mem_fault <= 1'b0;
            if (accept && !is_mem_op) begin
                // ALU or pass-through result: write back on the next cycle
                wb_valid <= 1'b1;
                w_enable <= ex_w_enable;
                w_select <= ex_w_select;
                w_reg    <= dest_reg;
                w_data   <= ex_result[31:0];
            end else if (accept && is_mem_op && misaligned) begin
                // misaligned: no request, fault pulse only
                mem_fault <= 1'b1;
            end else if (access_done) begin
                wb_valid <= 1'b1;
                w_enable <= !dmem_we;
                w_select <= lat_w_select;
                w_reg    <= lat_dest_reg;
                if (!dmem_we) begin
                    w_data <= dmem_rdata;
                end
            end else if (timeout_hit) begin
                mem_fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage. Inputs are driven on the
// falling edge and outputs are checked on the falling edge, so the
// values seen reflect the preceding rising edge.
// Define DMEM_TIMEOUT_EN to include the timeout scenarios (TIMEOUT_CYCLES = 4).
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [1:0]  mem_op;
    logic [32:0] ex_result;
    logic        ex_w_enable;
    logic        ex_w_select;
    logic [2:0]  dest_reg;
    logic [31:0] base_value;
    logic [15:0] offset;
    logic [31:0] store_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        wb_valid;
    logic        w_enable;
    logic        w_select;
    logic [2:0]  w_reg;
    logic [31:0] w_data;
    logic        mem_fault;
    logic        state_dbg;

    int checks = 0;
    int errors = 0;

    // clock
    always #5 clk = ~clk;

    mem_access_stage #(
        .ADDR_W        (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .mem_op     (mem_op),
        .ex_result  (ex_result),
        .ex_w_enable(ex_w_enable),
        .ex_w_select(ex_w_select),
        .dest_reg   (dest_reg),
        .base_value (base_value),
        .offset     (offset),
        .store_data (store_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .wb_valid   (wb_valid),
        .w_enable   (w_enable),
        .w_select   (w_select),
        .w_reg      (w_reg),
        .w_data     (w_data),
        .mem_fault  (mem_fault),
        .state_dbg  (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive_alu(input logic [32:0] res, input logic [2:0] dst, input logic wsel);
        ex_valid    = 1'b1;
        mem_op      = 2'b00;
        ex_result   = res;
        ex_w_enable = 1'b1;
        ex_w_select = wsel;
        dest_reg    = dst;
    endtask

    task automatic drive_mem(input logic [1:0] op, input logic [31:0] base, input logic [15:0] off,
                             input logic [31:0] sd, input logic [2:0] dst, input logic wsel);
        ex_valid    = 1'b1;
        mem_op      = op;
        base_value  = base;
        offset      = off;
        store_data  = sd;
        dest_reg    = dst;
        ex_w_select = wsel;
        ex_w_enable = 1'b1;
        ex_result   = 33'h0;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0;
        mem_op   = 2'b00;
    endtask

    initial begin
        reset       = 1'b1;
        ex_valid    = 1'b0;
        mem_op      = 2'b00;
        ex_result   = '0;
        ex_w_enable = 1'b0;
        ex_w_select = 1'b0;
        dest_reg    = '0;
        base_value  = '0;
        offset      = '0;
        store_data  = '0;
        dmem_rdata  = '0;
        dmem_ack    = 1'b0;
        step();
        step();

        // reset state
        check("rst_ex_ready", 32'(ex_ready), 32'd1);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_mem_fault", 32'(mem_fault), 32'd0);
        check("rst_w_data", w_data, 32'h0);
        check("rst_state", 32'(state_dbg), 32'd0);
        reset = 1'b0;

        // three back-to-back ALU ops; the carry bit must not leak out
        drive_alu(33'h1_0000_0005, 3'd1, 1'b0);
        step();
        check("alu1_valid", 32'(wb_valid), 32'd1);
        check("alu1_data", w_data, 32'h5);
        check("alu1_reg", 32'(w_reg), 32'd1);
        check("alu1_ready", 32'(ex_ready), 32'd1);
        drive_alu(33'h0_FFFF_FFFF, 3'd2, 1'b1);
        step();
        check("alu2_valid", 32'(wb_valid), 32'd1);
        check("alu2_data", w_data, 32'hFFFF_FFFF);
        check("alu2_reg", 32'(w_reg), 32'd2);
        check("alu2_sel", 32'(w_select), 32'd1);
        check("alu2_ready", 32'(ex_ready), 32'd1);
        drive_alu(33'h1_0000_0000, 3'd3, 1'b0);
        step();
        check("alu3_valid", 32'(wb_valid), 32'd1);
        check("alu3_data", w_data, 32'h0);
        check("alu3_reg", 32'(w_reg), 32'd3);
        check("alu3_wen", 32'(w_enable), 32'd1);
        idle_inputs();
        step();
        check("alu_pulse_end", 32'(wb_valid), 32'd0);
        check("alu_wen_end", 32'(w_enable), 32'd0);

        // load: 0x100 + (-4) = 0xFC, ack in the third request cycle
        drive_mem(2'b01, 32'h100, 16'hFFFC, 32'h0, 3'd4, 1'b1);
        step();
        idle_inputs();
        check("ld_req1", 32'(dmem_req), 32'd1);
        check("ld_addr", dmem_addr, 32'hFC);
        check("ld_we", 32'(dmem_we), 32'd0);
        check("ld_ready1", 32'(ex_ready), 32'd0);
        check("ld_nowb1", 32'(wb_valid), 32'd0);
        step();
        check("ld_req2", 32'(dmem_req), 32'd1);
        check("ld_ready2", 32'(ex_ready), 32'd0);
        step();
        check("ld_req3", 32'(dmem_req), 32'd1);
        check("ld_ready3", 32'(ex_ready), 32'd0);
        check("ld_addr3", dmem_addr, 32'hFC);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        step();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        check("ld_req_drop", 32'(dmem_req), 32'd0);
        check("ld_wb_valid", 32'(wb_valid), 32'd1);
        check("ld_wen", 32'(w_enable), 32'd1);
        check("ld_data", w_data, 32'hDEAD_BEEF);
        check("ld_reg", 32'(w_reg), 32'd4);
        check("ld_sel", 32'(w_select), 32'd1);
        check("ld_ready_back", 32'(ex_ready), 32'd1);

        // store: 0x20 + 4 = 0x24, ack in the first request cycle
        drive_mem(2'b10, 32'h20, 16'h0004, 32'h1234, 3'd5, 1'b0);
        step();
        idle_inputs();
        check("st_req", 32'(dmem_req), 32'd1);
        check("st_we", 32'(dmem_we), 32'd1);
        check("st_addr", dmem_addr, 32'h24);
        check("st_wdata", dmem_wdata, 32'h1234);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        check("st_req_drop", 32'(dmem_req), 32'd0);
        check("st_wb_valid", 32'(wb_valid), 32'd1);
        check("st_wen", 32'(w_enable), 32'd0);
        check("st_data_hold", w_data, 32'hDEAD_BEEF);

        // an ack while IDLE has no effect
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hAAAA_5555;
        step();
        dmem_ack   = 1'b0;
        check("idle_ack_wb", 32'(wb_valid), 32'd0);
        check("idle_ack_req", 32'(dmem_req), 32'd0);
        check("idle_ack_data", w_data, 32'hDEAD_BEEF);

        // misaligned load, then an ALU op on the very next cycle
        drive_mem(2'b01, 32'h3, 16'h0000, 32'h0, 3'd6, 1'b0);
        step();
        check("mis_req", 32'(dmem_req), 32'd0);
        check("mis_fault", 32'(mem_fault), 32'd1);
        check("mis_wb", 32'(wb_valid), 32'd0);
        check("mis_wen", 32'(w_enable), 32'd0);
        check("mis_ready", 32'(ex_ready), 32'd1);
        drive_alu(33'h0_0000_0077, 3'd6, 1'b0);
        step();
        idle_inputs();
        check("mis_fault_end", 32'(mem_fault), 32'd0);
        check("mis_next_wb", 32'(wb_valid), 32'd1);
        check("mis_next_data", w_data, 32'h77);

        // reset on the second ACCESS cycle, then a late ack
        drive_mem(2'b01, 32'h40, 16'h0000, 32'h0, 3'd7, 1'b0);
        step();
        idle_inputs();
        check("rsta_req1", 32'(dmem_req), 32'd1);
        step();
        check("rsta_req2", 32'(dmem_req), 32'd1);
        reset = 1'b1;
        step();
        reset      = 1'b0;
        check("rsta_req_low", 32'(dmem_req), 32'd0);
        check("rsta_wb", 32'(wb_valid), 32'd0);
        check("rsta_ready", 32'(ex_ready), 32'd1);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1111_2222;
        step();
        dmem_ack   = 1'b0;
        check("rsta_late_req", 32'(dmem_req), 32'd0);
        check("rsta_late_wb", 32'(wb_valid), 32'd0);
        check("rsta_late_ready", 32'(ex_ready), 32'd1);

`ifdef DMEM_TIMEOUT_EN
        // load with no ack: 4 request cycles, then a fault pulse
        drive_mem(2'b01, 32'h80, 16'h0000, 32'h0, 3'd2, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step();
            idle_inputs();
            check($sformatf("to_req%0d", i), 32'(dmem_req), 32'd1);
            check($sformatf("to_fault%0d", i), 32'(mem_fault), 32'd0);
        end
        step();
        check("to_req_drop", 32'(dmem_req), 32'd0);
        check("to_fault", 32'(mem_fault), 32'd1);
        check("to_nowb", 32'(wb_valid), 32'd0);
        check("to_ready", 32'(ex_ready), 32'd1);
        step();
        check("to_fault_end", 32'(mem_fault), 32'd0);

        // the ack lands on the terminal cycle and takes priority
        drive_mem(2'b01, 32'h84, 16'h0000, 32'h0, 3'd3, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            step();
            idle_inputs();
            check($sformatf("toa_req%0d", i), 32'(dmem_req), 32'd1);
        end
        step();
        check("toa_req4", 32'(dmem_req), 32'd1);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0BAD_F00D;
        step();
        dmem_ack   = 1'b0;
        check("toa_wb", 32'(wb_valid), 32'd1);
        check("toa_wen", 32'(w_enable), 32'd1);
        check("toa_data", w_data, 32'h0BAD_F00D);
        check("toa_reg", 32'(w_reg), 32'd3);
        check("toa_nofault", 32'(mem_fault), 32'd0);
        check("toa_req_drop", 32'(dmem_req), 32'd0);
`endif

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
